mux4_port_arbiter: RTL and testbench

//  Round-robin arbiter sharing one datapath resource (data-memory port) among 4 requesters.

---
 rtl/mux4_port_arbiter_pkg.sv | 13 +
 rtl/mux4_port_arbiter_rr_pick4.sv | 27 ++
 rtl/mux4_port_arbiter.sv | 109 ++++++++++
 tb/tb_mux4_port_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mux4_port_arbiter_pkg.sv
// Shared types and sizes for the 4-way data-memory port arbiter.
package mux4_port_arbiter_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_OWN,
    S_GAP
  } state_t;

endpackage

// File: rtl/mux4_port_arbiter_rr_pick4.sv
// Round-robin picker: first requester at or after last+1, wrapping; last itself ranks lowest.
module rr_pick4
  import mux4_port_arbiter_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // i == NREQ wraps to last, giving the previous owner the lowest priority
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = last + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_port_arbiter.sv
// Round-robin owner arbiter for a shared memory port: one-hot grant, hold limit, one-cycle turnaround.
module mux4_port_arbiter
  import mux4_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  localparam int unsigned      CNT_W     = $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] last_q, last_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             timeout_q, timeout_d;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             rel_done, rel_drop, at_limit, own_release;

  rr_pick4 u_pick (
    .req   (req),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign rel_done    = done[sel_q];
  assign rel_drop    = ~req[sel_q];
  assign at_limit    = (cnt_q == HOLD_LAST);
  assign own_release = rel_done | rel_drop | at_limit;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      last_q    <= SEL_W'(NREQ - 1);
      gnt_q     <= '0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_OWN: begin
        if (own_release) state_d = S_GAP;
        else             cnt_d   = cnt_q + CNT_W'(1);
      end
      default: begin
        if (pick_found) begin
          state_d = S_OWN;
          cnt_d   = '0;
          last_d  = pick_idx;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    case (state_q)
      S_OWN: begin
        if (own_release) begin
          gnt_d     = '0;
          // only a pure hold-limit release is reported as a timeout
          timeout_d = at_limit & ~rel_done & ~rel_drop;
        end
      end
      default: begin
        gnt_d = '0;
        if (pick_found) begin
          gnt_d[pick_idx] = 1'b1;
          sel_d           = pick_idx;
        end
      end
    endcase
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = |gnt_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_port_arbiter.sv
// Scoreboard bench for mux4_port_arbiter with MAX_HOLD=16.
module tb_mux4_port_arbiter;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } obs_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] done = '0;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mux4_port_arbiter #(.MAX_HOLD(16)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] g, input logic [1:0] s, input logic t);
    mk = {g, s, |g, t};
  endfunction

  function automatic obs_t observed();
    observed = {gnt, sel, busy, timeout};
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    req  = '0;
    done = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    #1 rstn = 1'b0;
    req = 4'hF;
    #2;
    o = observed(); e = mk('0, 2'd0, 1'b0); total++;
    if (o !== e) begin bad++; $display("FAIL reset_async got=%b want=%b", o, e); end
    @(posedge clk); #1;
    o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_held got=%b want=%b", o, e); end
    rstn = 1'b1;
    req  = '0;
    exp_q.push_back(mk('0, 2'd0, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL reset_idle got=%b want=%b", o, e); end
  endtask

  task automatic test_single_grant();
    obs_t o, e;
    for (int c = 0; c < 4; c++) begin
      req  = (c < 2) ? 4'b0001 : 4'b0000;
      done = (c == 1) ? 4'b0001 : 4'b0000;
      exp_q.push_back((c == 0) ? mk(4'b0001, 2'd0, 1'b0) : mk('0, 2'd0, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL single[%0d] got=%b want=%b", c, o, e); end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [3:0] g;
    logic [1:0] s;
    do_reset();
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      s = 2'(k % 4);
      g = 4'(1 << (k % 4));
      for (int c = 0; c < 3; c++) begin
        done = (c == 2) ? g : 4'b0000;
        exp_q.push_back((c == 2) ? mk('0, s, 1'b0) : mk(g, s, 1'b0));
        @(posedge clk); #1;
        e = exp_q.pop_front(); o = observed(); total++;
        if (o !== e) begin bad++; $display("FAIL rotate[%0d.%0d] got=%b want=%b", k, c, o, e); end
      end
    end
    req  = '0;
    done = '0;
    exp_q.push_back(mk('0, 2'd0, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL rotate_idle got=%b want=%b", o, e); end
  endtask

  task automatic test_hold_timeout();
    obs_t o, e;
    do_reset();
    req = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      if (c >= 18) req = '0;
      if (c < 16)       exp_q.push_back(mk(4'b0010, 2'd1, 1'b0));
      else if (c == 16) exp_q.push_back(mk('0, 2'd1, 1'b1));
      else if (c == 17) exp_q.push_back(mk(4'b0010, 2'd1, 1'b0));
      else              exp_q.push_back(mk('0, 2'd1, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL hold[%0d] got=%b want=%b", c, o, e); end
    end
  endtask

  task automatic test_done_at_limit();
    obs_t o, e;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 18; c++) begin
      done = (c == 4) ? 4'b0010 : (c == 16) ? 4'b0100 : 4'b0000;
      if (c == 17) req = '0;
      exp_q.push_back((c < 16) ? mk(4'b0100, 2'd2, 1'b0) : mk('0, 2'd2, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL done_limit[%0d] got=%b want=%b", c, o, e); end
    end
    done = '0;
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    do_reset();
    req = 4'b0100;
    exp_q.push_back(mk(4'b0100, 2'd2, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front(); o = observed(); total++;
    if (o !== e) begin bad++; $display("FAIL areset_own got=%b want=%b", o, e); end
    #2 rstn = 1'b0;
    #1;
    o = observed(); e = mk('0, 2'd0, 1'b0); total++;
    if (o !== e) begin bad++; $display("FAIL areset_drop got=%b want=%b", o, e); end
    req = 4'b1000;
    #1 rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) req = '0;
      exp_q.push_back((c == 0) ? mk(4'b1000, 2'd3, 1'b0) : mk('0, 2'd3, 1'b0));
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL areset_regrant[%0d] got=%b want=%b", c, o, e); end
    end
  endtask

  task automatic test_req_drop();
    obs_t o, e;
    logic [3:0] req_t  [7] = '{4'b0001, 4'b0100, 4'b0101, 4'b0101, 4'b0001, 4'b0000, 4'b0000};
    logic [3:0] done_t [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
    obs_t       exp_t  [7];
    exp_t[0] = mk(4'b0001, 2'd0, 1'b0);
    exp_t[1] = mk('0,      2'd0, 1'b0);
    exp_t[2] = mk(4'b0100, 2'd2, 1'b0);
    exp_t[3] = mk('0,      2'd2, 1'b0);
    exp_t[4] = mk(4'b0001, 2'd0, 1'b0);
    exp_t[5] = mk('0,      2'd0, 1'b0);
    exp_t[6] = mk('0,      2'd0, 1'b0);
    do_reset();
    for (int c = 0; c < 7; c++) begin
      req  = req_t[c];
      done = done_t[c];
      exp_q.push_back(exp_t[c]);
      @(posedge clk); #1;
      e = exp_q.pop_front(); o = observed(); total++;
      if (o !== e) begin bad++; $display("FAIL req_drop[%0d] got=%b want=%b", c, o, e); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_grant();
    test_back_to_back();
    test_hold_timeout();
    test_done_at_limit();
    test_async_reset();
    test_req_drop();
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
